// File: rtl/operand_feeder.sv
// operand_feeder
//   Upstream stage of the scheduled-datapath controller. It collects a serial
//   operand stream into one of two register banks. A set is NUM_OPS words,
//   and the first word of a set goes to index 0. While the controller
//   computes on one bank, the next set loads into the other bank.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last
//                   operand stream handshake; in_last marks the last word
//   dp_op_ready     controller is idle and can take a new set
//   dp_done         controller finished the issued set
//   dp_start        one-cycle start pulse to the controller
//   operands        active bank, operand i at [i*WIDTH +: WIDTH]
//   busy            a set has been issued and has not completed yet
//   frame_err       one-cycle pulse after a framing violation
//   set_count       completed sets, wraps modulo 256
module operand_feeder #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     dp_op_ready,
  input  logic                     dp_done,
  output logic                     dp_start,
  output logic [NUM_OPS*WIDTH-1:0] operands,
  output logic                     busy,
  output logic                     frame_err,
  output logic [7:0]               set_count
);

  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  logic [WIDTH-1:0] bank_r [2][NUM_OPS];
  logic [1:0]       full_r;
  logic             fill_ptr_r;
  logic             issue_ptr_r;
  logic             active_ptr_r;
  logic [IDX_W-1:0] fill_idx_r;
  logic             running_r;
  logic             frame_err_r;
  logic [7:0]       set_count_r;

  logic             accept_s;
  logic             at_last_s;
  logic             commit_s;
  logic             early_last_s;
  logic             frame_viol_s;
  logic             start_s;
  logic             done_s;
  logic [1:0]       full_nxt_s;

  // Handshake, framing and issue decisions for the current cycle.
  always_comb begin
    accept_s     = in_valid && !full_r[fill_ptr_r];
    at_last_s    = (fill_idx_r == LAST_IDX);
    commit_s     = accept_s && at_last_s;
    early_last_s = accept_s && !at_last_s && in_last;
    // A full set without in_last still commits, but it is reported.
    frame_viol_s = early_last_s || (commit_s && !in_last);
    start_s      = !running_r && full_r[issue_ptr_r] && dp_op_ready;
    done_s       = dp_done && running_r;
  end

  // Bank occupancy. A commit and a completion always target different banks:
  // the running bank is full, and a full bank cannot be filled.
  always_comb begin
    full_nxt_s = full_r;
    if (commit_s) begin
      full_nxt_s[fill_ptr_r] = 1'b1;
    end else begin
      full_nxt_s[fill_ptr_r] = full_r[fill_ptr_r];
    end
    if (done_s) begin
      full_nxt_s[active_ptr_r] = 1'b0;
    end else begin
      full_nxt_s[active_ptr_r] = full_nxt_s[active_ptr_r];
    end
  end

  // Operand storage. Words of a discarded partial set stay in the bank; the
  // next complete set overwrites every index before the bank is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_OPS; i++) begin
          bank_r[b][i] <= '0;
        end
      end
    end else if (accept_s) begin
      bank_r[fill_ptr_r][fill_idx_r] <= in_data;
    end
  end

  // Fill, issue and completion control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r       <= 2'b00;
      fill_ptr_r   <= 1'b0;
      issue_ptr_r  <= 1'b0;
      active_ptr_r <= 1'b0;
      fill_idx_r   <= '0;
      running_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      set_count_r  <= 8'd0;
    end else begin
      full_r      <= full_nxt_s;
      frame_err_r <= frame_viol_s;
      if (commit_s || early_last_s) begin
        fill_idx_r <= '0;
      end else if (accept_s) begin
        fill_idx_r <= fill_idx_r + IDX_W'(1);
      end
      if (commit_s) begin
        fill_ptr_r <= !fill_ptr_r;
      end
      if (start_s) begin
        running_r    <= 1'b1;
        active_ptr_r <= issue_ptr_r;
        issue_ptr_r  <= !issue_ptr_r;
      end else if (done_s) begin
        running_r   <= 1'b0;
        set_count_r <= set_count_r + 8'd1;
      end
    end
  end

  // Output view of the active bank and the status registers.
  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) begin
      operands[i*WIDTH +: WIDTH] = bank_r[active_ptr_r][i];
    end
    in_ready  = !full_r[fill_ptr_r];
    dp_start  = start_s;
    busy      = running_r;
    frame_err = frame_err_r;
    set_count = set_count_r;
  end

endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
- Upstream stage of the scheduled-datapath controller.
- Accepts a serial operand stream over valid/ready and packs NUM_OPS operands into one of two register banks (double buffer).
- Presents a stable operand vector to the datapath, issues a start pulse when the controller is ready, and frees the bank when the controller signals done.
- Lets the next operand set load while the current one computes.

Parameters:
WIDTH, 16, operand bit width
NUM_OPS, 8, operands per set (datapath register indices 0..NUM_OPS-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream word valid
in_data  input  WIDTH  operand word; first word of a set maps to index 0
in_last  input  1  marks final word of a set
in_ready  output  1  feeder can accept a word this cycle
dp_op_ready  input  1  controller idle, from controller op_ready
dp_done  input  1  controller done pulse, from controller done_next
dp_start  output  1  start pulse to controller
operands  output  NUM_OPS*WIDTH  active bank; operand i at bits [i*WIDTH +: WIDTH]
busy  output  1  a set is issued and not yet completed
frame_err  output  1  one-cycle pulse on framing violation
set_count  output  8  completed sets, wraps 255->0

Behaviour:
- Reset (async, rst=1): both banks cleared to 0; full[1:0]=0; fill_ptr=0, issue_ptr=0, fill_idx=0; running=0.
  - Outputs on reset: operands=0, in_ready=1, dp_start=0, busy=0, frame_err=0, set_count=0.
  - Reset mid-set or mid-computation discards everything; no pending start survives.
- Fill side:
  - in_ready = !full[fill_ptr].
  - Word accepted when in_valid && in_ready: bank[fill_ptr][fill_idx] <= in_data.
  - fill_idx increments on each accepted word.
  - fill_idx is ceil(log2(NUM_OPS)) bits; it never wraps past NUM_OPS-1.
- Commit (accepted word with fill_idx==NUM_OPS-1):
  - full[fill_ptr] <= 1, fill_ptr toggles, fill_idx <= 0.
  - If in_last=0 on this word: the bank still commits and frame_err pulses.
- Early last (in_last=1 with fill_idx<NUM_OPS-1):
  - The word is written, then the partial set is discarded: fill_idx <= 0, bank not marked full, fill_ptr unchanged.
  - frame_err pulses for one cycle, in the cycle after acceptance (registered).
- Issue side:
  - dp_start = !running && full[issue_ptr] && dp_op_ready. Combinational from registered state plus dp_op_ready; exactly one cycle per set.
  - On the dp_start edge: running <= 1, active_ptr <= issue_ptr, issue_ptr toggles.
  - operands always drives bank[active_ptr]. It must stay unchanged from dp_start through dp_done, because the controller reads operands across all schedule cycles.
  - Earliest dp_start is the cycle after the committing word is accepted.
- Completion:
  - dp_done while running: full[active_ptr] <= 0, running <= 0, set_count += 1.
  - The freed bank is writable (in_ready may rise) the next cycle.
  - dp_done while !running is ignored. No count change and no error.
- busy = running.
- Simultaneous events:
  - Commit into one bank in the same cycle as dp_done on the other: both take effect.
  - dp_done and dp_start cannot coincide, since dp_start requires !running.
  - Words may arrive every cycle. After both banks fill, in_ready=0 until a dp_done.
- Ordering: sets issue strictly in arrival order (banks alternate 0,1,0,...).

Test Plan:
- Single set: after reset, stream 1..8 (in_last on 8) with dp_op_ready=1.
  - dp_start pulses once, the cycle after word 8 is accepted.
  - operands = {8,7,...,1} (index0=1).
  - busy=1 until dp_done; then set_count=1, busy=0.
- Double buffering: stream set A=10..17 and set B=20..27 back-to-back; hold dp_done low.
  - in_ready drops after word 27.
  - Only A is issued; operands stay A.
  - After dp_done: dp_start fires for B the next cycle (dp_op_ready=1), operands=B, set_count=1.
- Backpressure: both banks full, in_valid=1, data 0x55.
  - in_ready=0 and no write; both banks unchanged.
  - After dp_done, 0x55 is accepted as index 0 of the freed bank.
- Early last: send 3 words with in_last on word 3, then a full set 1..8.
  - frame_err pulses once; no dp_start for the partial set.
  - Full set issues with index0=1.
- Missing last: 8 words with in_last=0.
  - frame_err pulses; the set still issues.
  - A spurious dp_done with busy=0 leaves set_count unchanged.
- Reset mid-computation: assert rst while busy=1 with the second bank full.
  - All outputs return to reset values, including operands=0 and set_count=0.
  - A fresh set then issues normally.
